mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port (I) and the load/store port (D).
- Replaces the separate instruction ROM and data RAM paths. Generates per-port stall signals for the pipeline.
- D has priority over I. A starvation guard forces an I grant after a bounded run of D grants.
- Sits between the fetch/memory stages and the memory, in the same clock domain as the core.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data width. Byte-strobe width is DATA_W/8.
- MAX_D_STREAK, 4, max consecutive D grants while I is waiting. 0 = strict D priority with no guard.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch data, valid while i_ack=1
- i_ack  out  1  fetch complete (1-cycle pulse)
- i_stall  out  1  i_req & ~i_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  data complete (1-cycle pulse)
- d_stall  out  1  d_req & ~d_ack
- mem_req  out  1  memory transaction valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Registered: state, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, streak counter.
- Reset (async, reset=0):
  - state=IDLE, streak=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - i_ack=d_ack=0.
  - Any in-flight transaction is abandoned; requesters reissue after reset.
- IDLE grant rule, evaluated each cycle:
  - Grant D if d_req & (~i_req | MAX_D_STREAK==0 | streak<MAX_D_STREAK).
  - Else grant I if i_req.
  - Else stay in IDLE.
- On grant:
  - Latch that port's request fields into the mem_* registers; set mem_req=1.
  - Next state is BUSY_D or BUSY_I.
  - An I grant forces mem_we=0 and mem_wstrb=0.
- BUSY_x:
  - mem_* outputs are held stable until mem_ready=1.
  - In the mem_ready cycle: x_ack=1 (combinational from mem_ready & state), x_rdata=mem_rdata (pass-through).
  - Same edge: mem_req clears, state returns to IDLE.
  - Ack data outside the ack cycle is don't-care; tie it to mem_rdata.
- Latency:
  - req sampled in IDLE at cycle 0 → mem_req high at cycle 1 → ack in the first cycle with mem_ready (earliest cycle 1).
  - Back-to-back: a new grant occurs in the IDLE cycle that follows each ack. Peak throughput is 1 transaction per 2 cycles.
- Requester contract:
  - req and payload are held stable until ack.
  - req may drop in the cycle after ack, or stay high to issue the next access.
  - If a requester drops req while BUSY, the transaction still completes and its ack pulse is ignored.
- Streak counter (width $clog2(MAX_D_STREAK+1), saturating):
  - +1 on each D grant while i_req=1.
  - Cleared on an I grant, or in any IDLE cycle with i_req=0.
- Simultaneous events:
  - i_req and d_req rise together → D is granted first (unless the streak limit is hit). I is granted on the next IDLE cycle.
  - mem_ready while IDLE → ignored.
- Never both acks in one cycle. At most one transaction is outstanding.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds 32-bit saturating counters perf_i_wait and perf_d_wait, output as ports of the same names.
  - Each counts cycles where its x_stall=1; cleared by reset.
- Undefined:
  - The ports still exist, tied to 0, so instantiations are unchanged.
  - No counter logic is generated.

Test Plan:
- Reset mid-BUSY_D (mem_ready held 0, reset pulsed low) → mem_req=0, state=IDLE, no d_ack. After release, d_req at 0x100 is regranted and mem_addr=0x100.
- Single fetch, i_addr=0x40, mem_ready=1 on the first mem_req cycle, mem_rdata=0x00500093 → i_ack pulses at cycle 1 with i_rdata=0x00500093; i_stall=1 only at cycle 0.
- Simultaneous i_req (0x0) and d_req store (0x200, wdata 0xDEADBEEF, wstrb 0xF) → D served first with mem_we=1, mem_wstrb=0xF. I is granted 1 cycle after d_ack, with mem_we=0.
- Starvation guard: MAX_D_STREAK=4, d_req and i_req held continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Variable latency: mem_ready delayed 5 cycles on a load → mem_addr, mem_we and mem_wdata stay stable for 5 cycles; d_stall=1 for 6 cycles; d_ack occurs exactly once.
- With MEM_ARB_PERF_CNT_EN defined, repeat the starvation scenario for 20 cycles → perf_i_wait equals the count of i_stall=1 cycles; without the macro, both counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch (I) and load/store (D) ports.
// Optional wait-cycle counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,
    output logic                  i_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [31:0]           perf_i_wait,
    output logic [31:0]           perf_d_wait
);

    localparam int STRB_W = DATA_W / 8;
    // A zero limit still needs a legal one-bit counter even though it never advances.
    localparam int STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                state_r;
    logic [STREAK_W-1:0]   streak_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [DATA_W-1:0]     mem_wdata_r;
    logic [STRB_W-1:0]     mem_wstrb_r;
    logic                  grant_d_s;
    logic                  grant_i_s;

    // Grant decision, only meaningful while IDLE.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (d_req && (!i_req || (MAX_D_STREAK == 0) || (streak_r < STREAK_MAX))) begin
                grant_d_s = 1'b1;
            end else if (i_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Main FSM: latches the granted request and holds it until the memory completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wstrb_r <= {STRB_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r     <= BUSY_D;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= d_we;
                        mem_addr_r  <= d_addr;
                        mem_wdata_r <= d_wdata;
                        mem_wstrb_r <= d_wstrb;
                    end else if (grant_i_s) begin
                        state_r     <= BUSY_I;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= i_addr;
                        mem_wdata_r <= {DATA_W{1'b0}};
                        mem_wstrb_r <= {STRB_W{1'b0}};
                    end else begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= state_r;
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Starvation guard: consecutive D grants while I waits, saturating at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_r <= {STREAK_W{1'b0}};
        end else if (grant_i_s || ((state_r == IDLE) && !i_req)) begin
            streak_r <= {STREAK_W{1'b0}};
        end else if (grant_d_s && (streak_r != STREAK_MAX)) begin
            streak_r <= streak_r + STREAK_W'(1);
        end else begin
            streak_r <= streak_r;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

    assign i_ack   = (state_r == BUSY_I) && mem_ready;
    assign d_ack   = (state_r == BUSY_D) && mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_stall = i_req && !i_ack;
    assign d_stall = d_req && !d_ack;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_wait_r;
    logic [31:0] perf_d_wait_r;

    // Saturating count of cycles the fetch port spends stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_wait_r <= 32'd0;
        end else if (i_stall && (perf_i_wait_r != 32'hFFFF_FFFF)) begin
            perf_i_wait_r <= perf_i_wait_r + 32'd1;
        end else begin
            perf_i_wait_r <= perf_i_wait_r;
        end
    end

    // Saturating count of cycles the load/store port spends stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_d_wait_r <= 32'd0;
        end else if (d_stall && (perf_d_wait_r != 32'hFFFF_FFFF)) begin
            perf_d_wait_r <= perf_d_wait_r + 32'd1;
        end else begin
            perf_d_wait_r <= perf_d_wait_r;
        end
    end

    assign perf_i_wait = perf_i_wait_r;
    assign perf_d_wait = perf_d_wait_r;
`else
    assign perf_i_wait = 32'd0;
    assign perf_d_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level reference model.
// Compiles with or without MEM_ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [SW-1:0] d_wstrb;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ack, d_ack, i_stall, d_stall, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;
    logic [31:0]   perf_i_wait, perf_d_wait;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: which port owns the memory (0 none, 1 I, 2 D) and the expected request.
    int            m_busy;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    int            m_streak;
    int            n_i_wait, n_d_wait;
    byte           grants[$];
    logic          e_i_ack, e_d_ack;

    // Values observed at the last sampling point.
    logic          o_i_ack, o_d_ack, o_i_stall, o_d_stall, o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, o_i_rdata, o_d_rdata;
    logic [SW-1:0] o_mem_wstrb;
    int            obs_i_stall_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample and check at the negedge, advance the model, return after the posedge.
    task automatic step();
        @(negedge clk);
        if (!reset) begin
            chk("rst_mem_req", mem_req, 1'b0);
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", mem_wstrb, 0);
            chk("rst_i_ack", i_ack, 1'b0);
            chk("rst_d_ack", d_ack, 1'b0);
            m_busy = 0; m_req = 1'b0; m_streak = 0;
            n_i_wait = 0; n_d_wait = 0; obs_i_stall_cnt = 0;
            e_i_ack = 1'b0; e_d_ack = 1'b0;
        end else begin
            e_i_ack = (m_busy == 1) && mem_ready;
            e_d_ack = (m_busy == 2) && mem_ready;
            chk("i_ack", i_ack, e_i_ack);
            chk("d_ack", d_ack, e_d_ack);
            chk("i_stall", i_stall, i_req && !e_i_ack);
            chk("d_stall", d_stall, d_req && !e_d_ack);
            chk("mem_req", mem_req, m_req);
            if (m_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, m_we);
                chk("mem_wstrb", mem_wstrb, m_wstrb);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (e_i_ack) chk("i_rdata", i_rdata, mem_rdata);
            if (e_d_ack) chk("d_rdata", d_rdata, mem_rdata);
`ifdef MEM_ARB_PERF_CNT_EN
            chk("perf_i_wait", perf_i_wait, n_i_wait);
            chk("perf_d_wait", perf_d_wait, n_d_wait);
`else
            chk("perf_i_zero", perf_i_wait, 0);
            chk("perf_d_zero", perf_d_wait, 0);
`endif
            if (i_req && !e_i_ack) n_i_wait++;
            if (d_req && !e_d_ack) n_d_wait++;
            if (i_stall === 1'b1) obs_i_stall_cnt++;
            if (m_busy != 0) begin
                if (mem_ready) begin
                    m_busy = 0;
                    m_req  = 1'b0;
                end
            end else if (d_req && (!i_req || MAXS == 0 || m_streak < MAXS)) begin
                m_busy = 2; m_req = 1'b1;
                m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_wstrb = d_wstrb;
                grants.push_back("D");
                if (i_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : m_streak;
                else       m_streak = 0;
            end else if (i_req) begin
                m_busy = 1; m_req = 1'b1;
                m_addr = i_addr; m_we = 1'b0; m_wstrb = '0;
                grants.push_back("I");
                m_streak = 0;
            end else begin
                m_streak = 0;
            end
        end
        o_i_ack = i_ack; o_d_ack = d_ack; o_i_stall = i_stall; o_d_stall = d_stall;
        o_mem_req = mem_req; o_mem_we = mem_we; o_mem_addr = mem_addr;
        o_mem_wdata = mem_wdata; o_mem_wstrb = mem_wstrb;
        o_i_rdata = i_rdata; o_d_rdata = d_rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    ds, da;
        string exp_order;
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
        step(); step();
        reset = 1'b1;
        step();

        // Reset in the middle of a D transaction, then regrant.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_wstrb = 4'h0;
        step(); step();
        chk("t1_busy_req", o_mem_req, 1'b1);
        reset = 1'b0;
        step();
        chk("t1_rst_req", o_mem_req, 1'b0);
        chk("t1_rst_dack", o_d_ack, 1'b0);
        reset = 1'b1;
        step(); step();
        chk("t1_regrant_req", o_mem_req, 1'b1);
        chk("t1_regrant_addr", o_mem_addr, 32'h0000_0100);
        mem_ready = 1'b1;
        step();
        chk("t1_dack", o_d_ack, 1'b1);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        // Single fetch with immediate ready.
        i_req = 1'b1; i_addr = 32'h0000_0040; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        chk("t2_stall_c0", o_i_stall, 1'b1);
        chk("t2_ack_c0", o_i_ack, 1'b0);
        step();
        chk("t2_ack_c1", o_i_ack, 1'b1);
        chk("t2_rdata", o_i_rdata, 32'h0050_0093);
        chk("t2_stall_c1", o_i_stall, 1'b0);
        chk("t2_addr", o_mem_addr, 32'h0000_0040);
        i_req = 1'b0; mem_ready = 1'b0;
        step();

        // Simultaneous requests: D store first, then I.
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        mem_ready = 1'b1;
        step();
        step();
        chk("t3_dack", o_d_ack, 1'b1);
        chk("t3_d_we", o_mem_we, 1'b1);
        chk("t3_d_wstrb", o_mem_wstrb, 4'hF);
        chk("t3_d_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();
        chk("t3_gap_req", o_mem_req, 1'b0);
        step();
        chk("t3_i_req", o_mem_req, 1'b1);
        chk("t3_i_we", o_mem_we, 1'b0);
        chk("t3_i_addr", o_mem_addr, 32'h0);
        chk("t3_iack", o_i_ack, 1'b1);
        i_req = 1'b0; mem_ready = 1'b0; d_we = 1'b0;
        step();

        // Starvation guard with both ports always requesting.
        grants.delete();
        exp_order = "DDDDIDDDDI";
        i_req = 1'b1; i_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; mem_ready = 1'b1;
        repeat (20) step();
        chk("t4_grant_cnt", grants.size(), 10);
        for (int k = 0; k < 10 && k < grants.size(); k++)
            chk("t4_grant_order", grants[k], exp_order[k]);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("t4_perf_i", perf_i_wait, obs_i_stall_cnt);
`else
        chk("t4_perf_i_off", perf_i_wait, 0);
        chk("t4_perf_d_off", perf_d_wait, 0);
`endif
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step();

        // Load with memory ready delayed by five cycles.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0140; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
        ds = 0; da = 0;
        step();
        ds += int'(o_d_stall); da += int'(o_d_ack);
        for (int k = 0; k < 5; k++) begin
            step();
            ds += int'(o_d_stall); da += int'(o_d_ack);
            chk("t5_addr_stable", o_mem_addr, 32'h0000_0140);
            chk("t5_we_stable", o_mem_we, 1'b0);
            chk("t5_wdata_stable", o_mem_wdata, 32'h1234_5678);
        end
        mem_ready = 1'b1;
        step();
        ds += int'(o_d_stall); da += int'(o_d_ack);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        ds += int'(o_d_stall); da += int'(o_d_ack);
        chk("t5_stall_cycles", ds, 6);
        chk("t5_ack_count", da, 1);

        // Randomized traffic with variable memory latency and one reset.
        for (int n = 0; n < 600; n++) begin
            reset = (n == 300) ? 1'b0 : 1'b1;
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            step();
            if (i_req) begin
                if (e_i_ack) begin
                    if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                    else i_addr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_req) begin
                if (e_d_ack) begin
                    if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                    else begin
                        d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
                    end
                end
            end else if ($urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
